// File: rtl/kronos_wb_scheduler_if.sv
// kronos_wb_scheduler_if: issue, writeback-source and regfile-write signals of the writeback scheduler
interface kronos_wb_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic                   flush;
    logic                   issue_vld;
    logic                   issue_rdy;
    logic                   issue_wr;
    logic [4:0]             issue_rd;
    logic                   issue_rs1_en;
    logic [4:0]             issue_rs1;
    logic                   issue_rs2_en;
    logic [4:0]             issue_rs2;
    logic [NUM_REQ-1:0]     wb_req;
    logic [NUM_REQ*5-1:0]   wb_sel;
    logic [NUM_REQ*32-1:0]  wb_data;
    logic [NUM_REQ-1:0]     wb_gnt;
    logic                   regwr_en;
    logic [4:0]             regwr_sel;
    logic [31:0]            regwr_data;
    logic                   stall;
    logic [31:0]            pending;
    modport master (
        output flush, issue_vld, issue_wr, issue_rd, issue_rs1_en, issue_rs1,
               issue_rs2_en, issue_rs2, wb_req, wb_sel, wb_data,
        input  issue_rdy, wb_gnt, regwr_en, regwr_sel, regwr_data, stall, pending
    );
    modport slave (
        input  flush, issue_vld, issue_wr, issue_rd, issue_rs1_en, issue_rs1,
               issue_rs2_en, issue_rs2, wb_req, wb_sel, wb_data,
        output issue_rdy, wb_gnt, regwr_en, regwr_sel, regwr_data, stall, pending
    );
endinterface

// File: rtl/kronos_wb_scheduler.sv
// kronos_wb_scheduler: round-robin regfile writeback arbiter with a RAW/WAW scoreboard
module kronos_wb_scheduler #(
    parameter int NUM_REQ = 3
) (
    input logic clk,
    input logic rst,
    kronos_wb_scheduler_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] rr_ptr, gnt_idx;
    logic          gnt_any;
    logic [4:0]    gnt_sel;
    logic [31:0]   gnt_data, pend, busy, clr, setv;
    logic          hazard, accept;
    always_comb begin
        bus.wb_gnt = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_sel = '0;
        gnt_data = '0;
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < NUM_REQ; i++)
                if (!rst && !gnt_any && bus.wb_req[i] && i == (int'(rr_ptr) + k) % NUM_REQ) begin
                    bus.wb_gnt[i] = 1'b1;
                    gnt_any = 1'b1;
                    gnt_idx = PW'(i);
                    gnt_sel = bus.wb_sel[5*i +: 5];
                    gnt_data = bus.wb_data[32*i +: 32];
                end
    end
    // A write committing this cycle no longer blocks its register
    assign clr = bus.regwr_en ? 32'd1 << bus.regwr_sel : 32'd0;
    assign busy = pend & ~clr;
    assign hazard = (bus.issue_rs1_en & busy[bus.issue_rs1]) |
                    (bus.issue_rs2_en & busy[bus.issue_rs2]) |
                    (bus.issue_wr & busy[bus.issue_rd]);
    assign bus.stall = bus.issue_vld & hazard;
    assign bus.issue_rdy = ~bus.stall;
    assign accept = bus.issue_vld & ~bus.stall & bus.issue_wr & (bus.issue_rd != 5'd0) & ~bus.flush;
    assign setv = accept ? 32'd1 << bus.issue_rd : 32'd0;
    assign bus.pending = pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            pend <= '0;
            bus.regwr_en <= 1'b0;
            bus.regwr_sel <= '0;
            bus.regwr_data <= '0;
        end else begin
            pend <= bus.flush ? 32'd0 : busy | setv;
            bus.regwr_en <= gnt_any && gnt_sel != 5'd0;
            if (gnt_any) begin
                bus.regwr_sel <= gnt_sel;
                bus.regwr_data <= gnt_data;
                rr_ptr <= gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_kronos_wb_scheduler.sv
// tb_kronos_wb_scheduler: random + directed scoreboard bench for the writeback scheduler
module tb_kronos_wb_scheduler;
    localparam int N = 3;
    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    kronos_wb_scheduler_if #(.NUM_REQ(N)) bus ();
    kronos_wb_scheduler #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic        r_req [N];
    logic [4:0]  r_sel [N];
    logic [31:0] r_data [N];
    logic        auto_drop;
    logic [31:0] m_pend;
    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_wsel;
    wr_t         exp_q [$];
    wr_t         mon_e;
    logic [N-1:0] last_gnt;
    logic        last_stall, last_wen;
    logic [2:0]  rr_seq [4];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask
    // Scoreboard view: a register blocks unless it is being written back right now
    function automatic logic blocked(input logic [4:0] r);
        return r != 5'd0 && m_pend[r] && !(m_wen && m_wsel == r);
    endfunction
    task automatic model_reset();
        m_pend = '0;
        m_ptr = 0;
        m_wen = 1'b0;
        m_wsel = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
    endtask
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.wb_req[i] = r_req[i];
            bus.wb_sel[5*i +: 5] = r_sel[i];
            bus.wb_data[32*i +: 32] = r_data[i];
        end
    endtask
    task automatic step();
        int gi = -1;
        logic [N-1:0] eg = '0;
        logic es, acc;
        drive();
        @(negedge clk);
        for (int k = 0; k < N; k++)
            if (gi < 0 && r_req[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
        if (gi >= 0) eg[gi] = 1'b1;
        es = bus.issue_vld && ((bus.issue_rs1_en && blocked(bus.issue_rs1)) ||
                               (bus.issue_rs2_en && blocked(bus.issue_rs2)) ||
                               (bus.issue_wr && blocked(bus.issue_rd)));
        chk("wb_gnt", 32'(bus.wb_gnt), 32'(eg));
        chk("stall", 32'(bus.stall), 32'(es));
        chk("issue_rdy", 32'(bus.issue_rdy), 32'(!es));
        chk("pending", bus.pending, m_pend);
        last_gnt = bus.wb_gnt;
        last_stall = bus.stall;
        last_wen = bus.regwr_en;
        @(posedge clk);
        acc = bus.issue_vld && !es && bus.issue_wr && bus.issue_rd != 5'd0 && !bus.flush;
        m_pend = bus.flush ? 32'd0 :
                 (m_pend & ~(m_wen ? 32'd1 << m_wsel : 32'd0)) | (acc ? 32'd1 << bus.issue_rd : 32'd0);
        if (gi >= 0) begin
            m_wen = r_sel[gi] != 5'd0;
            m_wsel = r_sel[gi];
            if (m_wen) exp_q.push_back('{sel: r_sel[gi], data: r_data[gi]});
            m_ptr = (gi + 1) % N;
            if (auto_drop) r_req[gi] = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        #1;
    endtask
    task automatic issue(input logic vld, input logic wr, input logic [4:0] rd,
                         input logic rs1_en, input logic [4:0] rs1);
        bus.issue_vld = vld;
        bus.issue_wr = wr;
        bus.issue_rd = rd;
        bus.issue_rs1_en = rs1_en;
        bus.issue_rs1 = rs1;
        bus.issue_rs2_en = 1'b0;
        bus.issue_rs2 = '0;
    endtask
    // Every registered write must match the next queued expectation, in order
    always @(negedge clk) begin
        if (!rst && bus.regwr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL regwr unexpected write sel %0d data %h", bus.regwr_sel, bus.regwr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("regwr_sel", 32'(bus.regwr_sel), 32'(mon_e.sel));
                chk("regwr_data", bus.regwr_data, mon_e.data);
            end
        end else if (!rst && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL regwr missing write got en 0 want sel %0d", mon_e.sel);
        end
    end
    initial begin
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        auto_drop = 1'b1;
        bus.flush = 1'b0;
        issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < N; i++) begin
            r_sel[i] = '0;
            r_data[i] = '0;
        end
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwr_en", 32'(bus.regwr_en), 32'd0);
        chk("rst_regwr_sel", 32'(bus.regwr_sel), 32'd0);
        chk("rst_regwr_data", bus.regwr_data, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_issue_rdy", 32'(bus.issue_rdy), 32'd1);
        rst = 1'b0;
        // Round-robin fairness with all sources held
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b1;
            r_sel[i] = 5'd5;
            r_data[i] = 32'hA0 + i;
        end
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr_seq", 32'(last_gnt), 32'(rr_seq[c]));
            if (c > 0) chk("rr_wen", 32'(last_wen), 32'd1);
        end
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
        auto_drop = 1'b1;
        step();
        step();
        // RAW on x7 resolved by a commit from source 1 with bypass
        issue(1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
        step();
        issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd7);
        step();
        chk("raw_stall", 32'(last_stall), 32'd1);
        r_req[1] = 1'b1;
        r_sel[1] = 5'd7;
        r_data[1] = 32'h0000_0777;
        step();
        chk("raw_stall_gnt", 32'(last_stall), 32'd1);
        step();
        chk("raw_bypass", 32'(last_stall), 32'd0);
        chk("raw_commit", 32'(last_wen), 32'd1);
        // WAW on x9 with set-wins against the commit
        issue(1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        step();
        issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        r_req[0] = 1'b1;
        r_sel[0] = 5'd9;
        r_data[0] = 32'h0000_0999;
        step();
        issue(1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        step();
        chk("waw_accept", 32'(last_stall), 32'd0);
        chk("waw_set_wins", bus.pending, 32'h0000_0200);
        // x0 never tracked, never written
        issue(1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        step();
        chk("x0_pending", bus.pending, 32'h0000_0200);
        issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        r_req[2] = 1'b1;
        r_sel[2] = 5'd0;
        r_data[2] = 32'hDEAD_0000;
        step();
        chk("x0_gnt", 32'(last_gnt), 32'd4);
        step();
        chk("x0_no_write", 32'(last_wen), 32'd0);
        // Flush clears the scoreboard and drops a same-cycle issue
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_clear", bus.pending, 32'd0);
        issue(1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
        step();
        issue(1'b1, 1'b1, 5'd10, 1'b0, 5'd0);
        step();
        chk("flush_pre", bus.pending, 32'h0000_0480);
        bus.flush = 1'b1;
        issue(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        r_req[0] = 1'b1;
        r_sel[0] = 5'd4;
        r_data[0] = 32'h0000_0444;
        step();
        chk("flush_gnt", 32'(last_gnt), 32'd1);
        bus.flush = 1'b0;
        issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("flush_drop", bus.pending, 32'd0);
        step();
        chk("flush_write", 32'(last_wen), 32'd1);
        // Asynchronous reset while a grant and a write are in flight
        r_req[1] = 1'b1;
        r_sel[1] = 5'd6;
        r_data[1] = 32'h0000_0666;
        r_req[2] = 1'b1;
        r_sel[2] = 5'd8;
        r_data[2] = 32'h0000_0888;
        issue(1'b1, 1'b1, 5'd12, 1'b0, 5'd0);
        step();
        issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        drive();
        #1;
        chk("prerst_gnt", 32'(bus.wb_gnt), 32'd4);
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(bus.wb_gnt), 32'd0);
        chk("midrst_regwr_en", 32'(bus.regwr_en), 32'd0);
        chk("midrst_pending", bus.pending, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (!r_req[i] && $urandom_range(1) == 1) begin
                    r_req[i] = 1'b1;
                    r_sel[i] = 5'($urandom_range(7));
                    r_data[i] = $urandom;
                end
            bus.flush = $urandom_range(19) == 0;
            bus.issue_vld = 1'($urandom_range(1));
            bus.issue_wr = 1'($urandom_range(1));
            bus.issue_rd = 5'($urandom_range(7));
            bus.issue_rs1_en = 1'($urandom_range(1));
            bus.issue_rs1 = 5'($urandom_range(7));
            bus.issue_rs2_en = 1'($urandom_range(1));
            bus.issue_rs2 = 5'($urandom_range(7));
            step();
        end
        for (int i = 0; i < N; i++) r_req[i] = 1'b0;
        bus.flush = 1'b0;
        issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) step();
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
